// File: rtl/isa_dma_responder.sv
// isa_dma_responder: riser-side ISA DMA responder for DRQ1/3/5/7.
// Arbitrates armed channels, runs SETUP/STROBE/HOLD/RECOVER bus cycles,
// buffers card->HPS words in a FWFT FIFO, and sources HPS->card words from
// the tx stream.
// Optional feature: define DMA_AUTOINIT_EN to enable per-channel auto-init
// (terminal count reloads the armed count instead of clearing busy).
module isa_dma_responder #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STROBE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       drq,
  output logic [3:0]       dack_n,
  output logic             aen,
  output logic             ior_n,
  output logic             iow_n,
  output logic             tc,
  input  logic [15:0]      data_bus_in,
  output logic [15:0]      data_bus_out,
  output logic             data_oe,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_chan,
  input  logic             cfg_dir,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_autoinit,
  output logic [3:0]       busy,
  output logic [3:0]       done,
  output logic [15:0]      rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [15:0]      tx_data,
  input  logic             tx_valid,
  output logic             tx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       ch;
  logic [SW-1:0]    scnt;
  logic [CNT_W-1:0] count [4];
  logic [3:0]       dir;
  logic [15:0]      data_q;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty, push, pop;
  logic [15:0]      push_word;
  logic [3:0]       eligible;
  logic             grant_found;
  logic [1:0]       grant_ch;
  logic             arm, cur_dir, cur_last, last_strobe;

`ifdef DMA_AUTOINIT_EN
  logic [CNT_W-1:0] reload [4];
  logic [3:0]       auto_mode;
`else
  logic             unused_autoinit;
  assign unused_autoinit = cfg_autoinit;
`endif

  assign cur_dir     = dir[ch];
  assign cur_last    = (count[ch] == '0);
  assign last_strobe = (state == S_STROBE) && (scnt == SW'(STROBE_CYCLES - 1));
  assign cfg_ready   = (state == S_IDLE) || (cfg_chan != ch);
  assign arm         = cfg_valid & cfg_ready;

  // FIFO status and push/pop qualification
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid   = ~fifo_empty;
  assign rx_data    = mem[rd_ptr[AW-1:0]];
  assign pop        = ~fifo_empty & rx_ready;
  assign push       = last_strobe & ~cur_dir;
  assign push_word  = ch[1] ? data_bus_in : {8'h00, data_bus_in[7:0]};

  // Drive tx_data straight through in SETUP so D is valid from the first
  // driven cycle; the latched copy covers the rest of the transfer.
  assign data_bus_out = (state == S_SETUP && cur_dir) ? tx_data : data_q;

  // Fixed-priority arbitration: lowest eligible index wins
  always_comb begin
    eligible    = '0;
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int unsigned i = 0; i < 4; i++)
      eligible[i] = busy[i] & drq[i] & (dir[i] ? tx_valid : ~fifo_full);
    for (int unsigned i = 4; i > 0; i--) begin
      if (eligible[i-1]) begin
        grant_found = 1'b1;
        grant_ch    = 2'(i - 1);
      end
    end
  end

  // Next-state and bus outputs for the transfer sequencer
  always_comb begin
    state_nxt = state;
    dack_n    = '1;
    aen       = 1'b0;
    ior_n     = 1'b1;
    iow_n     = 1'b1;
    tc        = 1'b0;
    data_oe   = 1'b0;
    tx_ready  = 1'b0;
    done      = '0;
    case (state)
      S_IDLE: begin
        if (grant_found) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        dack_n[ch] = 1'b0;
        aen        = 1'b1;
        data_oe    = cur_dir;
        tx_ready   = cur_dir;
        state_nxt  = S_STROBE;
      end
      S_STROBE: begin
        dack_n[ch] = 1'b0;
        aen        = 1'b1;
        data_oe    = cur_dir;
        ior_n      = cur_dir;
        iow_n      = ~cur_dir;
        tc         = cur_last;
        if (scnt == SW'(STROBE_CYCLES - 1)) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        dack_n[ch] = 1'b0;
        aen        = 1'b1;
        data_oe    = cur_dir;
        done[ch]   = cur_last;
        state_nxt  = S_RECOVER;
      end
      S_RECOVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, granted channel and strobe timer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ch    <= '0;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && grant_found) ch <= grant_ch;
      if (state == S_STROBE) scnt <= scnt + SW'(1);
      else                   scnt <= '0;
    end
  end

  // Per-channel arm state and transfer counts
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
      dir  <= '0;
      for (int unsigned i = 0; i < 4; i++) count[i] <= '0;
`ifdef DMA_AUTOINIT_EN
      auto_mode <= '0;
      for (int unsigned i = 0; i < 4; i++) reload[i] <= '0;
`endif
    end else begin
      // Active channel can never be re-armed here (cfg_ready blocks it),
      // so the HOLD update and the arm write never collide.
      if (state == S_HOLD) begin
        if (cur_last) begin
`ifdef DMA_AUTOINIT_EN
          if (auto_mode[ch]) count[ch] <= reload[ch];
          else               busy[ch]  <= 1'b0;
`else
          busy[ch] <= 1'b0;
`endif
        end else begin
          count[ch] <= count[ch] - CNT_W'(1);
        end
      end
      if (arm) begin
        count[cfg_chan] <= cfg_count;
        dir[cfg_chan]   <= cfg_dir;
        busy[cfg_chan]  <= 1'b1;
`ifdef DMA_AUTOINIT_EN
        reload[cfg_chan]    <= cfg_count;
        auto_mode[cfg_chan] <= cfg_autoinit;
`endif
      end
    end
  end

  // Latch the outgoing tx word at the end of SETUP
  always_ff @(posedge clk) begin
    if (reset)                           data_q <= '0;
    else if (state == S_SETUP && cur_dir) data_q <= tx_data;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_isa_dma_responder.sv
// tb_isa_dma_responder: directed bench with a transfer-timeline reference
// model compared every cycle, plus literal per-scenario expectations.
module tb_isa_dma_responder;

  localparam int S     = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  drq = '0;
  logic [3:0]  dack_n;
  logic        aen, ior_n, iow_n, tc;
  logic [15:0] data_bus_in = '0;
  logic [15:0] data_bus_out;
  logic        data_oe;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_chan = '0;
  logic        cfg_dir = 1'b0;
  logic [15:0] cfg_count = '0;
  logic        cfg_autoinit = 1'b0;
  logic [3:0]  busy, done;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;

  int n_vec = 0;
  int n_err = 0;

  isa_dma_responder #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W(16),
    .STROBE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .drq(drq), .dack_n(dack_n), .aen(aen),
    .ior_n(ior_n), .iow_n(iow_n), .tc(tc), .data_bus_in(data_bus_in),
    .data_bus_out(data_bus_out), .data_oe(data_oe), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_dir(cfg_dir),
    .cfg_count(cfg_count), .cfg_autoinit(cfg_autoinit), .busy(busy),
    .done(done), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_pos: -1 = no transfer, 0 = setup, 1..S = strobe, S+1 = hold, S+2 = recover
  logic [3:0]  m_busy = '0;
  logic [3:0]  m_dir  = '0;
  logic [3:0]  m_auto = '0;
  int unsigned m_cnt [4];
  int unsigned m_reload [4];
  int          m_pos = -1;
  int          m_ch  = 0;
  logic [15:0] m_dbo = '0;
  logic [15:0] m_q [$];

  task automatic model_step();
    int   pick;
    bit   arm_ok, do_pop;
    int   pos_n;
    if (reset) begin
      m_busy = '0; m_dir = '0; m_auto = '0; m_pos = -1; m_ch = 0; m_dbo = '0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_reload[i] = 0; end
      return;
    end
    arm_ok = cfg_valid && !(m_pos >= 0 && int'(cfg_chan) == m_ch);
    do_pop = (m_q.size() > 0) && rx_ready;
    pos_n  = m_pos;
    if (m_pos < 0) begin
      pick = -1;
      for (int i = 3; i >= 0; i--)
        if (m_busy[i] && drq[i] && (m_dir[i] ? tx_valid : (m_q.size() < DEPTH))) pick = i;
      if (pick >= 0) begin m_ch = pick; pos_n = 0; end
    end else begin
      if (m_pos == 0 && m_dir[m_ch]) m_dbo = tx_data;
      if (do_pop) begin void'(m_q.pop_front()); do_pop = 0; end
      if (m_pos == S && !m_dir[m_ch])
        m_q.push_back(m_ch >= 2 ? data_bus_in : {8'h00, data_bus_in[7:0]});
      if (m_pos == S + 1) begin
        if (m_cnt[m_ch] == 0) begin
`ifdef DMA_AUTOINIT_EN
          if (m_auto[m_ch]) m_cnt[m_ch] = m_reload[m_ch];
          else              m_busy[m_ch] = 1'b0;
`else
          m_busy[m_ch] = 1'b0;
`endif
        end else m_cnt[m_ch] = m_cnt[m_ch] - 1;
      end
      pos_n = (m_pos == S + 2) ? -1 : m_pos + 1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (arm_ok) begin
      m_cnt[cfg_chan] = cfg_count; m_reload[cfg_chan] = cfg_count;
      m_dir[cfg_chan] = cfg_dir; m_auto[cfg_chan] = cfg_autoinit;
      m_busy[cfg_chan] = 1'b1;
    end
    m_pos = pos_n;
  endtask

  task automatic model_compare();
    logic [3:0]  e_dack, e_done;
    logic        e_aen, e_ior, e_iow, e_tc, e_oe, e_txr, e_rdy;
    logic [15:0] e_dbo;
    bit active, strobe, d;
    active = (m_pos >= 0) && (m_pos <= S + 1);
    strobe = (m_pos >= 1) && (m_pos <= S);
    d      = (m_pos >= 0) ? m_dir[m_ch] : 1'b0;
    e_dack = 4'hF; e_done = 4'h0;
    if (active) e_dack[m_ch] = 1'b0;
    if (m_pos == S + 1 && m_cnt[m_ch] == 0) e_done[m_ch] = 1'b1;
    e_aen = active;
    e_ior = !(strobe && !d);
    e_iow = !(strobe && d);
    e_tc  = strobe && (m_cnt[m_ch] == 0);
    e_oe  = active && d;
    e_txr = (m_pos == 0) && d;
    e_rdy = !(m_pos >= 0 && int'(cfg_chan) == m_ch);
    e_dbo = (m_pos == 0) ? tx_data : m_dbo;
    chk("dack_n", {28'd0, dack_n}, {28'd0, e_dack});
    chk("aen", {31'd0, aen}, {31'd0, e_aen});
    chk("ior_n", {31'd0, ior_n}, {31'd0, e_ior});
    chk("iow_n", {31'd0, iow_n}, {31'd0, e_iow});
    chk("tc", {31'd0, tc}, {31'd0, e_tc});
    chk("data_oe", {31'd0, data_oe}, {31'd0, e_oe});
    chk("tx_ready", {31'd0, tx_ready}, {31'd0, e_txr});
    chk("done", {28'd0, done}, {28'd0, e_done});
    chk("busy", {28'd0, busy}, {28'd0, m_busy});
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, e_rdy});
    chk("rx_valid", {31'd0, rx_valid}, {31'd0, logic'(m_q.size() > 0)});
    if (m_q.size() > 0) chk("rx_data", {16'd0, rx_data}, {16'd0, m_q[0]});
    if (e_oe) chk("data_bus_out", {16'd0, data_bus_out}, {16'd0, e_dbo});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_compare();
    end
  end

  // ---------------- event monitor for literal checks ----------------
  int   ior_cyc = 0, iow_cyc = 0, tc_cyc = 0, txr_cyc = 0, oe_cyc = 0, oe_beef = 0;
  int   done_cnt [4] = '{0, 0, 0, 0};
  int   grant_log [$];
  logic [3:0] prev_dack = 4'hF;

  initial begin
    forever begin
      @(negedge clk);
      if (ior_n === 1'b0) ior_cyc++;
      if (iow_n === 1'b0) iow_cyc++;
      if (tc === 1'b1) tc_cyc++;
      if (tx_ready === 1'b1) txr_cyc++;
      if (data_oe === 1'b1) oe_cyc++;
      if (data_oe === 1'b1 && data_bus_out === 16'hBEEF) oe_beef++;
      for (int i = 0; i < 4; i++) if (done[i] === 1'b1) done_cnt[i]++;
      if (dack_n !== 4'hF && prev_dack === 4'hF)
        for (int i = 0; i < 4; i++) if (dack_n[i] === 1'b0) grant_log.push_back(i);
      prev_dack = dack_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic arm(input int c, input bit d, input int unsigned n, input bit a);
    cfg_chan = 2'(c); cfg_dir = d; cfg_count = 16'(n); cfg_autoinit = a; cfg_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_busy_clear(input logic [3:0] mask, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((busy & mask) == 4'h0) break;
    end
    chk(name, {28'd0, busy & mask}, 32'd0);
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp);
    chk({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
    chk({name, "_data"}, {16'd0, rx_data}, {16'd0, exp});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int s_ior, s_iow, s_tc, s_txr, s_oe, s_beef, s_done, g0, s_d2;
    int exp_order [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_dack_n", {28'd0, dack_n}, 32'hF);
    chk("rst_aen", {31'd0, aen}, 32'd0);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data_bus_out", {16'd0, data_bus_out}, 32'd0);
    chk("rst_data_oe", {31'd0, data_oe}, 32'd0);
    tick();

    // ch1 card->HPS, three 8-bit transfers
    s_ior = ior_cyc; s_tc = tc_cyc; s_done = done_cnt[1]; g0 = grant_log.size();
    data_bus_in = 16'h12A5;
    drq = 4'b0010;
    arm(1, 1'b0, 2, 1'b0);
    wait_busy_clear(4'b0010, 100, "s1_busy_timeout");
    tick();
    drq = 4'b0000;
    chk("s1_ior_cycles", 32'(ior_cyc - s_ior), 32'd12);
    chk("s1_tc_cycles", 32'(tc_cyc - s_tc), 32'd4);
    chk("s1_done_pulses", 32'(done_cnt[1] - s_done), 32'd1);
    chk("s1_grants", 32'(grant_log.size() - g0), 32'd3);
    for (int i = g0; i < grant_log.size(); i++) chk("s1_grant_ch", 32'(grant_log[i]), 32'd1);
    for (int k = 0; k < 3; k++) pop_check("s1_rx", 16'h00A5);
    chk("s1_rx_empty", {31'd0, rx_valid}, 32'd0);

    // ch3 HPS->card, single 16-bit transfer
    s_iow = iow_cyc; s_tc = tc_cyc; s_txr = txr_cyc; s_oe = oe_cyc; s_beef = oe_beef;
    s_done = done_cnt[3]; g0 = grant_log.size();
    tx_data = 16'hBEEF; tx_valid = 1'b1;
    drq = 4'b1000;
    arm(3, 1'b1, 0, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_ready) break;
    end
    chk("s2_tx_ready_seen", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 1'b0; tx_data = 16'h0000;
    wait_busy_clear(4'b1000, 50, "s2_busy_timeout");
    tick();
    drq = 4'b0000;
    chk("s2_iow_cycles", 32'(iow_cyc - s_iow), 32'd4);
    chk("s2_tc_cycles", 32'(tc_cyc - s_tc), 32'd4);
    chk("s2_tx_ready_cycles", 32'(txr_cyc - s_txr), 32'd1);
    chk("s2_oe_cycles", 32'(oe_cyc - s_oe), 32'd6);
    chk("s2_oe_beef_cycles", 32'(oe_beef - s_beef), 32'd6);
    chk("s2_done_pulses", 32'(done_cnt[3] - s_done), 32'd1);
    chk("s2_grants", 32'(grant_log.size() - g0), 32'd1);

    // all four channels requesting: fixed-priority order
    g0 = grant_log.size();
    rx_ready = 1'b1;
    data_bus_in = 16'hABCD;
    drq = 4'b1111;
    arm(0, 1'b0, 1, 1'b0);
    arm(1, 1'b0, 1, 1'b0);
    arm(2, 1'b0, 1, 1'b0);
    arm(3, 1'b0, 1, 1'b0);
    wait_busy_clear(4'b1111, 200, "s3_busy_timeout");
    tick();
    drq = 4'b0000;
    tick();
    rx_ready = 1'b0;
    chk("s3_grants", 32'(grant_log.size() - g0), 32'd8);
    for (int i = 0; i < 8; i++)
      if (g0 + i < grant_log.size()) chk("s3_grant_order", 32'(grant_log[g0 + i]), 32'(exp_order[i]));

    // FIFO full stalls dir0 grants until a pop
    g0 = grant_log.size();
    data_bus_in = 16'h5A3C;
    drq = 4'b0001;
    arm(0, 1'b0, 16, 1'b0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (grant_log.size() - g0 >= 16) break;
    end
    repeat (40) @(negedge clk);
    chk("s4_grants_full", 32'(grant_log.size() - g0), 32'd16);
    chk("s4_busy_held", {31'd0, busy[0]}, 32'd1);
    tick();
    pop_check("s4_pop", 16'h003C);
    wait_busy_clear(4'b0001, 60, "s4_busy_timeout");
    chk("s4_grants_total", 32'(grant_log.size() - g0), 32'd17);
    tick();
    drq = 4'b0000;
    rx_ready = 1'b1;
    repeat (20) tick();
    rx_ready = 1'b0;
    chk("s4_drained", {31'd0, rx_valid}, 32'd0);

    // reset asserted mid-STROBE
    s_ior = ior_cyc;
    data_bus_in = 16'h0077;
    drq = 4'b0100;
    arm(2, 1'b0, 5, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ior_cyc - s_ior >= 5) break;
    end
    chk("s5_in_strobe", {31'd0, ior_n}, 32'd0);
    chk("s5_rx_before", {31'd0, rx_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("s5_ior_n", {31'd0, ior_n}, 32'd1);
    chk("s5_dack_n", {28'd0, dack_n}, 32'hF);
    chk("s5_aen", {31'd0, aen}, 32'd0);
    chk("s5_busy", {28'd0, busy}, 32'd0);
    chk("s5_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("s5_done", {28'd0, done}, 32'd0);
    reset = 1'b0;
    drq = 4'b0000;
    tick();

    // ch2 count=1 with autoinit requested
    s_tc = tc_cyc; s_d2 = done_cnt[2]; g0 = grant_log.size();
    rx_ready = 1'b1;
    data_bus_in = 16'h1111;
    drq = 4'b0100;
    arm(2, 1'b0, 1, 1'b1);
`ifdef DMA_AUTOINIT_EN
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_cnt[2] - s_d2 >= 2) break;
    end
    chk("s6_grants", 32'(grant_log.size() - g0), 32'd4);
    chk("s6_tc_cycles", 32'(tc_cyc - s_tc), 32'd8);
    chk("s6_busy_kept", {31'd0, busy[2]}, 32'd1);
    tick();
    arm(2, 1'b0, 0, 1'b0);
    wait_busy_clear(4'b0100, 60, "s6_busy_timeout");
`else
    repeat (60) @(negedge clk);
    chk("s6_grants", 32'(grant_log.size() - g0), 32'd2);
    chk("s6_tc_cycles", 32'(tc_cyc - s_tc), 32'd4);
    chk("s6_done_pulses", 32'(done_cnt[2] - s_d2), 32'd1);
    chk("s6_busy_cleared", {31'd0, busy[2]}, 32'd0);
`endif
    tick();
    drq = 4'b0000;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
